// File: rtl/board_update_arb.sv
// Shares the board cell RAM between N_REQ writers: one buffered write per requester,
// committed round-robin only inside vertical blanking, with a per-window write budget.
module board_update_arb #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 7,
  parameter int VAL_W  = 4,
  parameter int MAX_WR = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      vblnk_in,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*VAL_W-1:0]    req_val,
  output logic [N_REQ-1:0]          req_err,
  output logic                      ram_we,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [VAL_W-1:0]          ram_wdata,
  output logic                      frame_tick,
  output logic [7:0]                wr_count
);

  localparam int PTR_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int LAST_CELL = 80;

  typedef enum logic [1:0] {IDLE, WINDOW, HOLD} state_t;

  state_t                state_q, state_d;
  logic                  vblnk_d_q;
  logic [N_REQ-1:0]      pend_q, pend_d;
  logic [PTR_W-1:0]      rr_q, rr_d;
  logic [ADDR_W-1:0]     buf_addr_q [N_REQ];
  logic [ADDR_W-1:0]     buf_addr_d [N_REQ];
  logic [VAL_W-1:0]      buf_val_q  [N_REQ];
  logic [VAL_W-1:0]      buf_val_d  [N_REQ];
  logic                  ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]     ram_addr_q, ram_addr_d;
  logic [VAL_W-1:0]      ram_wdata_q, ram_wdata_d;
  logic [N_REQ-1:0]      req_err_q, req_err_d;
  logic                  frame_tick_q, frame_tick_d;
  logic [7:0]            wr_count_q, wr_count_d;

  logic [N_REQ-1:0]      accept;
  logic                  found;
  logic [PTR_W-1:0]      win;
  int                    idx;
  logic [ADDR_W-1:0]     svc_addr;
  logic [VAL_W-1:0]      svc_val;

  function automatic logic addr_legal(input logic [ADDR_W-1:0] a);
    return int'(a) <= LAST_CELL;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (int'(c) >= MAX_WR) ? c : c + 8'd1;
  endfunction

  // Ready is held low while reset is asserted, not just until the first clock.
  assign req_ready = ~pend_q & {N_REQ{rst_n}};
  assign accept    = req_valid & req_ready;

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    rr_d         = rr_q;
    buf_addr_d   = buf_addr_q;
    buf_val_d    = buf_val_q;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    req_err_d    = '0;
    frame_tick_d = 1'b0;
    wr_count_d   = wr_count_q;
    found        = 1'b0;
    win          = '0;
    idx          = 0;

    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_q) + k) % N_REQ;
      if (!found && pend_q[PTR_W'(idx)]) begin
        found = 1'b1;
        win   = PTR_W'(idx);
      end
    end
    svc_addr = buf_addr_q[win];
    svc_val  = buf_val_q[win];

    case (state_q)
      IDLE: begin
        if (vblnk_in && !vblnk_d_q) begin
          state_d      = WINDOW;
          frame_tick_d = 1'b1;
          wr_count_d   = 8'd0;
        end
      end
      WINDOW: begin
        if (!vblnk_in) begin
          state_d = IDLE;
        end else if (found) begin
          pend_d[win] = 1'b0;
          rr_d        = PTR_W'((int'(win) + 1) % N_REQ);
          if (addr_legal(svc_addr)) begin
            ram_we_d    = 1'b1;
            ram_addr_d  = svc_addr;
            ram_wdata_d = svc_val;
            wr_count_d  = sat_inc(wr_count_q);
            if (wr_count_d == 8'(MAX_WR)) state_d = HOLD;
          end else begin
            // Illegal cell: the slot is consumed but the write budget is not.
            req_err_d[win] = 1'b1;
          end
        end
      end
      HOLD: begin
        if (!vblnk_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A requester being serviced is never accepting, so these never collide.
    pend_d = pend_d | accept;
    for (int i = 0; i < N_REQ; i++) begin
      if (accept[i]) begin
        buf_addr_d[i] = req_addr[i*ADDR_W +: ADDR_W];
        buf_val_d[i]  = req_val[i*VAL_W +: VAL_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      vblnk_d_q    <= 1'b0;
      pend_q       <= '0;
      rr_q         <= '0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      req_err_q    <= '0;
      frame_tick_q <= 1'b0;
      wr_count_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      vblnk_d_q    <= vblnk_in;
      pend_q       <= pend_d;
      rr_q         <= rr_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      req_err_q    <= req_err_d;
      frame_tick_q <= frame_tick_d;
      wr_count_q   <= wr_count_d;
    end
  end

  // Buffer contents are only meaningful while pend is set, so they need no reset.
  always_ff @(posedge clk) begin
    buf_addr_q <= buf_addr_d;
    buf_val_q  <= buf_val_d;
  end

  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign req_err    = req_err_q;
  assign frame_tick = frame_tick_q;
  assign wr_count   = wr_count_q;

endmodule

// File: tb/tb_board_update_arb.sv
// Directed bench for board_update_arb: a frame-level reference model checked every cycle,
// plus hand-computed expectations at key points of each scenario.
module tb_board_update_arb;

  localparam int N  = 2;
  localparam int AW = 7;
  localparam int VW = 4;
  localparam int MW = 2;

  logic            clk;
  logic            rst_n;
  logic            vblnk_in;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*VW-1:0] req_val;
  logic [N-1:0]    req_err;
  logic            ram_we;
  logic [AW-1:0]   ram_addr;
  logic [VW-1:0]   ram_wdata;
  logic            frame_tick;
  logic [7:0]      wr_count;

  int total = 0;
  int bad   = 0;

  board_update_arb #(.N_REQ(N), .ADDR_W(AW), .VAL_W(VW), .MAX_WR(MW)) dut (
    .clk(clk), .rst_n(rst_n), .vblnk_in(vblnk_in),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_val(req_val), .req_err(req_err),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .frame_tick(frame_tick), .wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: buffered writes, an open/closed blanking window and a budget counter.
  bit       m_pend [N];
  int       m_addr [N];
  int       m_val  [N];
  int       m_ptr  = 0;
  bit       m_open = 0;
  bit       m_prev = 0;
  bit       e_we   = 0;
  int       e_addr = 0;
  int       e_data = 0;
  bit [N-1:0] e_err = '0;
  bit       e_tick = 0;
  int       e_cnt  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) m_pend[i] = 0;
      m_ptr = 0; m_open = 0; m_prev = 0;
      e_we = 0; e_addr = 0; e_data = 0; e_err = '0; e_tick = 0; e_cnt = 0;
    end else begin
      bit was [N];
      int w;
      for (int i = 0; i < N; i++) was[i] = m_pend[i];
      e_we = 0; e_err = '0; e_tick = 0;
      if (!m_open) begin
        if (vblnk_in && !m_prev) begin
          m_open = 1; e_tick = 1; e_cnt = 0;
        end
      end else if (!vblnk_in) begin
        m_open = 0;
      end else if (e_cnt < MW) begin
        w = -1;
        for (int k = 0; k < N; k++)
          if (w < 0 && was[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        if (w >= 0) begin
          m_pend[w] = 0;
          m_ptr = (w + 1) % N;
          if (m_addr[w] <= 80) begin
            e_we = 1; e_addr = m_addr[w]; e_data = m_val[w]; e_cnt++;
          end else begin
            e_err[w] = 1'b1;
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && !was[i]) begin
          m_pend[i] = 1;
          m_addr[i] = int'(req_addr[i*AW +: AW]);
          m_val[i]  = int'(req_val[i*VW +: VW]);
        end
      end
      m_prev = vblnk_in;
    end
  end

  always @(posedge clk) begin
    logic [N-1:0] e_rdy;
    #1;
    for (int i = 0; i < N; i++) e_rdy[i] = rst_n && !m_pend[i];
    chk("m_ram_we", ram_we, e_we);
    chk("m_ram_addr", ram_addr, e_addr);
    chk("m_ram_wdata", ram_wdata, e_data);
    chk("m_req_err", req_err, e_err);
    chk("m_frame_tick", frame_tick, e_tick);
    chk("m_wr_count", wr_count, e_cnt);
    chk("m_req_ready", req_ready, e_rdy);
  end

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic post();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int i, input int a, input int v);
    neg();
    req_valid[i] = 1'b1;
    req_addr[i*AW +: AW] = AW'(a);
    req_val[i*VW +: VW]  = VW'(v);
    neg();
    req_valid[i] = 1'b0;
  endtask

  task automatic push2(input int a0, input int v0, input int a1, input int v1);
    neg();
    req_valid = 2'b11;
    req_addr  = {AW'(a1), AW'(a0)};
    req_val   = {VW'(v1), VW'(v0)};
    neg();
    req_valid = 2'b00;
  endtask

  task automatic vb(input logic v);
    neg();
    vblnk_in = v;
  endtask

  initial begin
    rst_n = 1'b1; vblnk_in = 1'b0; req_valid = '0; req_addr = '0; req_val = '0;
    #2 rst_n = 1'b0;
    repeat (3) neg();
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_we", ram_we, 0);
    chk("rst_count", wr_count, 0);
    rst_n = 1'b1;
    #1 chk("rel_ready", req_ready, 2'b11);

    // Single write held through active video, committed two cycles after vblank rises.
    push(0, 12, 5);
    repeat (3) post();
    chk("t1_no_we_active", ram_we, 0);
    chk("t1_busy", req_ready, 2'b10);
    vb(1'b1);
    post();
    chk("t1_tick", frame_tick, 1);
    chk("t1_we_early", ram_we, 0);
    post();
    chk("t1_we", ram_we, 1);
    chk("t1_addr", ram_addr, 12);
    chk("t1_data", ram_wdata, 5);
    chk("t1_count", wr_count, 1);
    post();
    chk("t1_we_once", ram_we, 0);
    chk("t1_addr_hold", ram_addr, 12);
    vb(1'b0);
    repeat (3) neg();

    // Illegal address from req1: error pulse, no write, budget untouched.
    push(1, 81, 3);
    vb(1'b1);
    post();
    post();
    chk("t3_err", req_err, 2'b10);
    chk("t3_no_we", ram_we, 0);
    chk("t3_count", wr_count, 0);
    chk("t3_ready", req_ready, 2'b11);
    vb(1'b0);
    repeat (3) neg();

    // Both pending with pointer at 0: req0 then req1, twice.
    for (int r = 0; r < 2; r++) begin
      push2(20 + 20*r, 1 + r, 30 + 20*r, 2 + r);
      vb(1'b1);
      post();
      post();
      chk("t2_first", ram_addr, 20 + 20*r);
      chk("t2_first_data", ram_wdata, 1 + r);
      post();
      chk("t2_second", ram_addr, 30 + 20*r);
      chk("t2_second_data", ram_wdata, 2 + r);
      chk("t2_count", wr_count, 2);
      vb(1'b0);
      repeat (3) neg();
    end

    // Budget of 2: req0 refilled mid-window waits for the next window.
    push2(60, 8, 61, 9);
    vb(1'b1);
    post();
    post();
    chk("t4_w1", ram_addr, 60);
    neg();
    req_valid = 2'b01; req_addr[0 +: AW] = AW'(62); req_val[0 +: VW] = VW'(10);
    post();
    chk("t4_w2", ram_addr, 61);
    chk("t4_count_full", wr_count, 2);
    chk("t4_refill_ready", req_ready, 2'b10);
    neg();
    req_valid = 2'b00;
    repeat (3) post();
    chk("t4_hold_no_we", ram_we, 0);
    chk("t4_hold_count", wr_count, 2);
    vb(1'b0);
    repeat (2) neg();
    vb(1'b1);
    post();
    chk("t4_tick", frame_tick, 1);
    chk("t4_cleared", wr_count, 0);
    post();
    chk("t4_w3", ram_addr, 62);
    chk("t4_w3_data", ram_wdata, 10);
    chk("t4_count_next", wr_count, 1);
    vb(1'b0);
    repeat (3) neg();

    // One-cycle vblank: window closes before service, pending survives.
    push(1, 5, 4);
    vb(1'b1);
    vb(1'b0);
    post();
    chk("t5_no_we", ram_we, 0);
    chk("t5_still_pend", req_ready, 2'b01);
    repeat (3) neg();
    vb(1'b1);
    post();
    post();
    chk("t5_late_we", ram_we, 1);
    chk("t5_late_addr", ram_addr, 5);
    chk("t5_late_data", ram_wdata, 4);
    vb(1'b0);
    repeat (3) neg();

    // Reset in the middle of a window with a write in flight.
    push2(70, 1, 71, 2);
    vb(1'b1);
    post();
    post();
    chk("t6_pre_we", ram_we, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_we_cut", ram_we, 0);
    chk("t6_ready_low", req_ready, 2'b00);
    chk("t6_count_clr", wr_count, 0);
    repeat (2) neg();
    rst_n = 1'b1;
    repeat (5) post();
    chk("t6_no_later_we", ram_we, 0);
    chk("t6_count_zero", wr_count, 0);
    chk("t6_ready", req_ready, 2'b11);
    vb(1'b0);
    repeat (3) neg();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
